// File: rtl/array_ctrl_pkg.sv
// Shared constants and types for the array access controller and its arbiter.
// The optional post-reset array clear is enabled by defining ARRAY_INIT_CLEAR_EN.
package array_ctrl_pkg;

   localparam int DEPTH  = 128;
   localparam int WIDTH  = 51;
   localparam int ADDR_W = 7;

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Identifies which read requester owns an in-flight response.
   typedef logic req_id_t;
   localparam req_id_t REQ_R0 = 1'b0;
   localparam req_id_t REQ_R1 = 1'b1;

   function automatic logic [1:0] pickOne(input logic [1:0] req, input logic ptr);
      logic [1:0] gnt;
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
      return gnt;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the loser on contention.
// Part of array_access_ctrl (ARRAY_INIT_CLEAR_EN has no effect here).
module rr_arb2
   import array_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic rrPtr;

   assign grant = enable ? pickOne(req, rrPtr) : 2'b00;

   // Only real contention advances the pointer, so a lone requester never steals the next turn.
   always_ff @(posedge clock) begin
      if (reset) begin
         rrPtr <= 1'b0;
      end else if (enable && (req == 2'b11)) begin
         rrPtr <= ~rrPtr;
      end
   end

endmodule

// File: rtl/array_access_ctrl.sv
// Read-port arbiter, response router and write pass-through for a 128x51 1R1W array macro.
// Define ARRAY_INIT_CLEAR_EN to zero the whole array after every reset before accepting traffic.
module array_access_ctrl
   import array_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              io_r0_req_valid,
   output logic              io_r0_req_ready,
   input  logic [ADDR_W-1:0] io_r0_req_addr,
   output logic              io_r0_resp_valid,
   output logic [WIDTH-1:0]  io_r0_resp_data,
   input  logic              io_r1_req_valid,
   output logic              io_r1_req_ready,
   input  logic [ADDR_W-1:0] io_r1_req_addr,
   output logic              io_r1_resp_valid,
   output logic [WIDTH-1:0]  io_r1_resp_data,
   input  logic              io_w_req_valid,
   output logic              io_w_req_ready,
   input  logic [ADDR_W-1:0] io_w_req_addr,
   input  logic [WIDTH-1:0]  io_w_req_data,
   output logic              io_init_done,
   output logic              sram_R0_en,
   output logic [ADDR_W-1:0] sram_R0_addr,
   input  logic [WIDTH-1:0]  sram_R0_data,
   output logic              sram_W0_en,
   output logic [ADDR_W-1:0] sram_W0_addr,
   output logic [WIDTH-1:0]  sram_W0_data,
   output logic              sram_W0_mask
);

   state_t            state;
   logic              run;
   logic [1:0]        grant;
   logic              clearWe;
   logic [ADDR_W-1:0] clearAddr;
   logic              rdPend;
   req_id_t           rdOwner;
   logic              bypHit;
   logic [WIDTH-1:0]  bypData;

`ifdef ARRAY_INIT_CLEAR_EN
   logic [ADDR_W-1:0] clearCnt;

   // Clear writes are registered, so the sweep finishes one cycle after the counter wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_INIT;
         clearCnt  <= '0;
         clearWe   <= 1'b0;
         clearAddr <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (clearWe && (clearAddr == ADDR_W'(DEPTH - 1))) begin
                  state   <= S_RUN;
                  clearWe <= 1'b0;
               end else begin
                  clearWe   <= 1'b1;
                  clearAddr <= clearCnt;
                  clearCnt  <= clearCnt + 1'b1;
               end
            end
            S_RUN: begin
               state   <= S_RUN;
               clearWe <= 1'b0;
            end
            default: state <= S_INIT;
         endcase
      end
   end
`else
   assign clearWe   = 1'b0;
   assign clearAddr = '0;

   always_ff @(posedge clock) begin
      state <= S_RUN;
   end
`endif

   // Gating with reset keeps every ready and enable low while reset is held.
   assign run          = (state == S_RUN) && !reset;
   assign io_init_done = run;

   rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .enable (run),
      .req    ({io_r1_req_valid, io_r0_req_valid}),
      .grant  (grant)
   );

   assign io_r0_req_ready = grant[0];
   assign io_r1_req_ready = grant[1];
   assign sram_R0_en      = |grant;
   assign sram_R0_addr    = grant[1] ? io_r1_req_addr : io_r0_req_addr;

   assign io_w_req_ready = run;
   assign sram_W0_en     = run ? io_w_req_valid : clearWe;
   assign sram_W0_addr   = run ? io_w_req_addr : clearAddr;
   assign sram_W0_data   = run ? io_w_req_data : '0;
   assign sram_W0_mask   = 1'b1;

   // A same-cycle write to the address being read is forwarded so the reader sees the new data.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdPend  <= 1'b0;
         rdOwner <= REQ_R0;
         bypHit  <= 1'b0;
         bypData <= '0;
      end else begin
         rdPend  <= |grant;
         if (|grant) begin
            rdOwner <= grant[1] ? REQ_R1 : REQ_R0;
         end
         bypHit  <= (|grant) && io_w_req_valid && (io_w_req_addr == sram_R0_addr);
         bypData <= io_w_req_data;
      end
   end

   assign io_r0_resp_valid = rdPend && (rdOwner == REQ_R0) && !reset;
   assign io_r1_resp_valid = rdPend && (rdOwner == REQ_R1) && !reset;
   assign io_r0_resp_data  = bypHit ? bypData : sram_R0_data;
   assign io_r1_resp_data  = io_r0_resp_data;

endmodule
